// File: rtl/writeback_buffer.sv
// In-order writeback queue feeding the register-file write port, with a
// youngest-match forwarding lookup for two decode read ports.
module writeback_buffer #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         res_valid,
    output logic         res_ready,
    input  logic [4:0]   res_addr,
    input  logic [N-1:0] res_data,
    input  logic         hold,
    input  logic         flush,
    output logic         regWrite_W,
    output logic [4:0]   wa3_W,
    output logic [N-1:0] writeData3_W,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic         hit1,
    output logic         hit2,
    output logic [N-1:0] fwd1,
    output logic [N-1:0] fwd2,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]    addr_q [DEPTH];
    logic [N-1:0]  data_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign res_ready = !full;

    // XZR results complete the handshake but never occupy an entry
    assign push = res_valid && res_ready && (res_addr != XZR) && !flush;
    assign pop  = !empty && !hold && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= res_addr;
            data_q[tail] <= res_data;
        end
    end

    always_comb begin
        regWrite_W   = pop;
        wa3_W        = '0;
        writeData3_W = '0;
        if (!empty) begin
            wa3_W        = addr_q[head];
            writeData3_W = data_q[head];
        end
    end

    // Walk oldest to youngest so later matches override earlier ones
    always_comb begin
        logic [AW-1:0] idx;
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (ra1 != XZR && addr_q[idx] == ra1) begin
                    hit1 = 1'b1;
                    fwd1 = data_q[idx];
                end
                if (ra2 != XZR && addr_q[idx] == ra2) begin
                    hit2 = 1'b1;
                    fwd2 = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: register-file writes are checked by a
// scoreboard monitor, status and forwarding outputs by direct checks.
module tb_writeback_buffer;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset, res_valid, res_ready, hold, flush;
    logic [4:0]   res_addr, ra1, ra2, wa3_W;
    logic [N-1:0] res_data, writeData3_W, fwd1, fwd2;
    logic         regWrite_W, hit1, hit2, empty, full;

    typedef struct {
        logic [4:0]   a;
        logic [N-1:0] d;
    } wr_t;
    wr_t sb[$];

    int errors = 0;
    int checks = 0;

    writeback_buffer #(.N(N), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr(res_addr), .res_data(res_data),
        .hold(hold), .flush(flush),
        .regWrite_W(regWrite_W), .wa3_W(wa3_W), .writeData3_W(writeData3_W),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] a, input logic [N-1:0] d);
        res_valid = 1'b1;
        res_addr  = a;
        res_data  = d;
        if (res_ready && a != 5'd31 && !flush && !reset)
            sb.push_back('{a: a, d: d});
        step();
        res_valid = 1'b0;
    endtask

    // Scoreboard monitor: every register-file write must match the oldest expected entry
    always @(negedge clk) begin
        if (regWrite_W) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write", wa3_W, writeData3_W);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (wa3_W !== e.a || writeData3_W !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%0h expected addr=%0d data=%0h",
                             wa3_W, writeData3_W, e.a, e.d);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; res_valid = 1'b0; res_addr = '0; res_data = '0;
        hold = 1'b0; flush = 1'b0; ra1 = '0; ra2 = '0;
        repeat (2) step();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", res_ready, 1);
        check("rst_regwrite", regWrite_W, 0);
        check("rst_wa3", wa3_W, 0);
        check("rst_wd3", writeData3_W, 0);
        check("rst_hit1", hit1, 0);
        check("rst_fwd1", fwd1, 0);
        reset = 1'b0;

        // single result, one-cycle latency; retiring entry still forwards
        send(5'd5, 64'h1234);
        ra1 = 5'd5;
        #1;
        check("single_regwrite", regWrite_W, 1);
        check("single_wa3", wa3_W, 5);
        check("single_wd3", writeData3_W, 64'h1234);
        check("retire_hit1", hit1, 1);
        check("retire_fwd1", fwd1, 64'h1234);
        step();
        check("single_empty", empty, 1);
        check("single_idle", regWrite_W, 0);
        check("single_nohit", hit1, 0);

        // fill under hold, refused fifth push, in-order drain
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) send(5'(i), N'(i * 8'h11));
        check("fill_full", full, 1);
        check("fill_ready", res_ready, 0);
        check("fill_hold", regWrite_W, 0);
        send(5'd9, 64'h99);
        check("refused_full", full, 1);
        check("refused_head", wa3_W, 1);
        hold = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_regwrite", regWrite_W, 1);
            step();
        end
        check("drain_empty", empty, 1);
        check("drain_sb", sb.size(), 0);

        // simultaneous push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            send(5'(i), N'(i * 3));
            check("wrap_notfull", full, 0);
            check("wrap_head", wa3_W, 5'(i));
        end
        check("wrap_last", regWrite_W, 1);
        step();
        check("wrap_empty", empty, 1);
        check("wrap_sb", sb.size(), 0);

        // youngest-match forwarding
        hold = 1'b1;
        send(5'd7, 64'hA);
        send(5'd7, 64'hB);
        ra1 = 5'd7; ra2 = 5'd8;
        #1;
        check("fwd_hit1", hit1, 1);
        check("fwd_fwd1", fwd1, 64'hB);
        check("fwd_hit2", hit2, 0);
        check("fwd_fwd2", fwd2, 0);
        ra1 = 5'd31;
        #1;
        check("xzr_hit1", hit1, 0);
        check("xzr_fwd1", fwd1, 0);

        // flush with a simultaneous push
        send(5'd3, 64'h33);
        ra1 = 5'd7;
        flush = 1'b1; res_valid = 1'b1; res_addr = 5'd4; res_data = 64'h44;
        #1;
        check("flush_hit1", hit1, 1);
        check("flush_fwd1", fwd1, 64'hB);
        check("flush_nowrite", regWrite_W, 0);
        sb.delete();
        step();
        flush = 1'b0; res_valid = 1'b0; hold = 1'b0;
        #1;
        check("flush_empty", empty, 1);
        check("flush_idle", regWrite_W, 0);
        check("flush_nohit", hit1, 0);
        repeat (2) step();

        // reset with queued entries and a simultaneous push
        hold = 1'b1;
        send(5'd1, 64'h101);
        send(5'd2, 64'h202);
        send(5'd3, 64'h303);
        reset = 1'b1; res_valid = 1'b1; res_addr = 5'd6; res_data = 64'h66;
        sb.delete();
        step();
        reset = 1'b0; res_valid = 1'b0; hold = 1'b0; ra1 = 5'd3;
        #1;
        check("rst2_empty", empty, 1);
        check("rst2_full", full, 0);
        check("rst2_ready", res_ready, 1);
        check("rst2_regwrite", regWrite_W, 0);
        check("rst2_wa3", wa3_W, 0);
        check("rst2_wd3", writeData3_W, 0);
        check("rst2_hit1", hit1, 0);
        repeat (2) step();

        // XZR result is consumed but never written
        check("xzr_ready", res_ready, 1);
        send(5'd31, 64'hFF);
        check("xzr_empty", empty, 1);
        check("xzr_noforward", hit1, 0);
        repeat (3) step();

        check("final_sb", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Write-side counterpart of the decode stage's register-file read path.
- Accepts completed results (destination register plus data) from execute/memory, queues them in a small in-order FIFO, and retires one per cycle into the register file write port (regWrite, wa3, writeData3).
- Provides a youngest-match forwarding lookup, so decode reads of registers with queued writes get the pending value instead of stale register-file contents.

Parameters:
- N, 64, datapath width of result data.
- DEPTH, 4, number of queue entries; power of two, 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- res_valid  input  1  producer presents a result this cycle.
- res_ready  output  1  buffer can accept a result this cycle.
- res_addr  input  5  destination register number.
- res_data  input  N  result value.
- hold  input  1  suppresses retirement this cycle (register-file port busy).
- flush  input  1  discards all queued entries.
- regWrite_W  output  1  write enable to the register file.
- wa3_W  output  5  write address to the register file.
- writeData3_W  output  N  write data to the register file.
- ra1, ra2  input  5  decode read addresses for the forwarding lookup.
- hit1, hit2  output  1  a queued entry targets ra1/ra2.
- fwd1, fwd2  output  N  data of the youngest matching entry; 0 when no hit.
- empty, full  output  1  queue status.

Behaviour:
- State: DEPTH entries {addr[4:0], data[N-1:0]}; head and tail pointers of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
- Reset: count=0, pointers=0, empty=1, full=0, res_ready=1, regWrite_W=0, wa3_W=0, writeData3_W=0, hit1=hit2=0, fwd1=fwd2=0. Entry storage need not be cleared.
- Accept:
  - res_ready = !full, combinational from count.
  - Push occurs when res_valid && res_ready.
  - A result with res_addr==31 (XZR) is handshaken (consumed) but not enqueued.
- Retire:
  - regWrite_W = !empty && !hold && !flush.
  - wa3_W and writeData3_W present the head entry whenever !empty; they are 0 when empty.
  - The head pops on the same edge the register file samples the write.
- Latency: a result accepted at edge k drives regWrite_W in the cycle after edge k, provided the queue was empty and hold=0. There is no combinational bypass from res_* to regWrite_W.
- Simultaneous push and pop: count unchanged, both pointers advance.
- When full, push is refused even if a pop happens in the same cycle; res_ready depends only on the registered count.
- Pointers wrap modulo DEPTH.
- Forwarding lookup:
  - Combinational over all valid entries, youngest (closest to tail) wins.
  - ra==31 never hits; fwd=0 in that case.
  - The entry currently being retired still counts as a hit in that cycle.
- flush: on the edge, count=0 and head=tail=0. Any push in the same cycle is dropped; flush has priority over push and pop. While flush=1, hit1/hit2 are still evaluated on current contents.
- reset has priority over flush; reset mid-drain abandons remaining entries with no further writes.

Test Plan:
- Single result: reset, push addr=5 data=0x1234 -> next cycle regWrite_W=1, wa3_W=5, writeData3_W=0x1234; following cycle empty=1, regWrite_W=0.
- Fill and full: with hold=1, push addr 1..4 data 0x11..0x44 -> full=1, res_ready=0. A fifth push is not accepted. Release hold -> regWrite_W asserted for addr 1,2,3,4 in order over 4 consecutive cycles.
- Simultaneous push/pop with wrap: hold=0, push one result every cycle for 10 cycles (addr=i, data=i*3) -> retirement in order, count stays ≤1, pointers wrap past DEPTH with no loss or duplication.
- Forwarding youngest: hold=1, push addr=7 data=0xA then addr=7 data=0xB; ra1=7, ra2=8 -> hit1=1, fwd1=0xB, hit2=0, fwd2=0. ra1=31 -> hit1=0.
- XZR discard: push addr=31 data=0xFF -> res_ready=1, handshake completes, empty stays 1, regWrite_W never asserts.
- Flush and reset: queue 3 entries with hold=1; assert flush together with a push -> next cycle empty=1, no regWrite_W. Repeat with reset instead -> all outputs return to reset values in one cycle.
